// File: rtl/mem_access_if.sv
// Data RAM bus between the MEM-stage access unit and the data memory.
interface mem_access_if;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_ready;
    logic [31:0] ram_read_data;

    modport master (
        output ram_en,
        output ram_write_en,
        output ram_addr,
        output ram_write_data,
        input  ram_ready,
        input  ram_read_data
    );

    modport slave (
        input  ram_en,
        input  ram_write_en,
        input  ram_addr,
        input  ram_write_data,
        output ram_ready,
        output ram_read_data
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage memory access unit: issues one data RAM request per load/store,
// stalls the pipeline until the bus completes or times out, then presents
// the aligned and extended load value (or the ALU result) for write-back.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] result,
    mem_access_if.master bus,
    output logic [31:0] result_out,
    output logic        stall_request,
    output logic        addr_error,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] rdata_q;
    logic [31:0] timeout_cnt;

    logic        is_mem;
    logic        misaligned;
    logic        op_valid;
    logic [31:0] store_data;
    logic [31:0] shifted;
    logic [31:0] load_value;

    // Decode the current instruction: alignment, store lane replication.
    always_comb begin
        is_mem     = mem_read_flag | mem_write_flag;
        misaligned = ((mem_sel == 4'b0011) && result[0]) ||
                     ((mem_sel == 4'b1111) && (result[1:0] != 2'b00));
        op_valid   = is_mem && !misaligned;
        case (mem_sel)
            4'b0001: store_data = {4{mem_write_data[7:0]}};
            4'b0011: store_data = {2{mem_write_data[15:0]}};
            default: store_data = mem_write_data;
        endcase
    end

    // Extract the addressed byte/half from the captured word and extend it.
    always_comb begin
        shifted = rdata_q >> {result[1:0], 3'b000};
        case (mem_sel)
            4'b0001: load_value = {{24{shifted[7] & mem_sign_ext_flag}}, shifted[7:0]};
            4'b0011: load_value = {{16{shifted[15] & mem_sign_ext_flag}}, shifted[15:0]};
            default: load_value = rdata_q;
        endcase
    end

    // Pipeline-facing outputs, combinational from state and held inputs.
    always_comb begin
        stall_request = 1'b0;
        addr_error    = 1'b0;
        result_out    = result;
        case (state)
            IDLE: begin
                if (is_mem && misaligned) begin
                    addr_error = 1'b1;
                    result_out = '0;
                end else if (op_valid) begin
                    stall_request = 1'b1;
                end
            end
            ACCESS: stall_request = 1'b1;
            DONE: begin
                // Both flags set is treated as a store, so the write flag wins.
                if (!mem_write_flag && mem_read_flag)
                    result_out = load_value;
            end
            default: ;
        endcase
    end

    // Access FSM with registered bus outputs; ready is checked before timeout
    // so a completion in the last counted cycle is never reported as an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            bus.ram_en         <= 1'b0;
            bus.ram_write_en   <= '0;
            bus.ram_addr       <= '0;
            bus.ram_write_data <= '0;
            rdata_q            <= '0;
            timeout_cnt        <= '0;
            bus_error          <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        bus.ram_en         <= 1'b1;
                        bus.ram_write_en   <= mem_write_flag ? (mem_sel << result[1:0]) : 4'b0000;
                        bus.ram_addr       <= {result[31:2], 2'b00};
                        bus.ram_write_data <= store_data;
                        timeout_cnt        <= '0;
                        state              <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.ram_ready) begin
                        rdata_q          <= bus.ram_read_data;
                        bus.ram_en       <= 1'b0;
                        bus.ram_write_en <= '0;
                        state            <= DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (timeout_cnt == TIMEOUT_CYCLES - 1)) begin
                        rdata_q          <= '0;
                        bus.ram_en       <= 1'b0;
                        bus.ram_write_en <= '0;
                        bus_error        <= 1'b1;
                        state            <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a short timeout to reach the error path.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] result;
    logic [31:0] result_out;
    logic        stall_request;
    logic        addr_error;
    logic        bus_error;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mem_access_if bus_if ();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_flag     (mem_read_flag),
        .mem_write_flag    (mem_write_flag),
        .mem_sign_ext_flag (mem_sign_ext_flag),
        .mem_sel           (mem_sel),
        .mem_write_data    (mem_write_data),
        .result            (result),
        .bus               (bus_if.master),
        .result_out        (result_out),
        .stall_request     (stall_request),
        .addr_error        (addr_error),
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [31:0] res);
        mem_read_flag     = rd;
        mem_write_flag    = wr;
        mem_sign_ext_flag = sx;
        mem_sel           = sel;
        mem_write_data    = wd;
        result            = res;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.ram_ready     = 1'b0;
        bus_if.ram_read_data = '0;
        set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0000_0123);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_ram_en",   {31'd0, bus_if.ram_en}, 32'd0);
        check_eq("rst_we",       {28'd0, bus_if.ram_write_en}, 32'd0);
        check_eq("rst_addr",     bus_if.ram_addr, 32'd0);
        check_eq("rst_wdata",    bus_if.ram_write_data, 32'd0);
        check_eq("rst_bus_err",  {31'd0, bus_error}, 32'd0);
        check_eq("rst_stall",    {31'd0, stall_request}, 32'd0);
        check_eq("rst_result",   result_out, 32'h0000_0123);

        // LB at 0x1003, ready on first ACCESS cycle
        set_op(1, 0, 1, 4'b0001, 32'h0, 32'h0000_1003);
        check_eq("lb_stall_c0",  {31'd0, stall_request}, 32'd1);
        check_eq("lb_ram_en_c0", {31'd0, bus_if.ram_en}, 32'd0);
        tick();
        check_eq("lb_stall_c1",  {31'd0, stall_request}, 32'd1);
        check_eq("lb_ram_en_c1", {31'd0, bus_if.ram_en}, 32'd1);
        check_eq("lb_addr",      bus_if.ram_addr, 32'h0000_1000);
        check_eq("lb_we",        {28'd0, bus_if.ram_write_en}, 32'd0);
        bus_if.ram_ready     = 1'b1;
        bus_if.ram_read_data = 32'h80FF_FF12;
        tick();
        bus_if.ram_ready = 1'b0;
        #1;
        check_eq("lb_stall_done", {31'd0, stall_request}, 32'd0);
        check_eq("lb_result",     result_out, 32'hFFFF_FF80);
        check_eq("lb_ram_en_done", {31'd0, bus_if.ram_en}, 32'd0);
        tick();

        // SH at 0x2002, ready after 3 wait cycles (ready on the last counted cycle)
        set_op(0, 1, 0, 4'b0011, 32'h1234_ABCD, 32'h0000_2002);
        check_eq("sh_stall_c0", {31'd0, stall_request}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                bus_if.ram_ready = 1'b1;
                #1;
            end
            check_eq($sformatf("sh_we_%0d", i),    {28'd0, bus_if.ram_write_en}, 32'h0000_000C);
            check_eq($sformatf("sh_wdata_%0d", i), bus_if.ram_write_data, 32'hABCD_ABCD);
            check_eq($sformatf("sh_en_%0d", i),    {31'd0, bus_if.ram_en}, 32'd1);
            check_eq($sformatf("sh_stall_%0d", i), {31'd0, stall_request}, 32'd1);
        end
        tick();
        bus_if.ram_ready = 1'b0;
        #1;
        check_eq("sh_stall_done", {31'd0, stall_request}, 32'd0);
        check_eq("sh_bus_err",    {31'd0, bus_error}, 32'd0);
        check_eq("sh_result",     result_out, 32'h0000_2002);
        check_eq("sh_we_done",    {28'd0, bus_if.ram_write_en}, 32'd0);
        tick();

        // LW at 0x3001: misaligned
        set_op(1, 0, 1, 4'b1111, 32'h0, 32'h0000_3001);
        check_eq("lw_mis_addr_err", {31'd0, addr_error}, 32'd1);
        check_eq("lw_mis_stall",    {31'd0, stall_request}, 32'd0);
        check_eq("lw_mis_result",   result_out, 32'd0);
        tick();
        check_eq("lw_mis_ram_en",   {31'd0, bus_if.ram_en}, 32'd0);
        check_eq("lw_mis_stall2",   {31'd0, stall_request}, 32'd0);

        // LHU at 0x4000, ready stuck low -> timeout after 4 ACCESS cycles
        bus_if.ram_read_data = 32'hDEAD_BEEF;
        set_op(1, 0, 0, 4'b0011, 32'h0, 32'h0000_4000);
        check_eq("to_addr_err", {31'd0, addr_error}, 32'd0);
        check_eq("to_stall_c0", {31'd0, stall_request}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("to_en_%0d", i),    {31'd0, bus_if.ram_en}, 32'd1);
            check_eq($sformatf("to_stall_%0d", i), {31'd0, stall_request}, 32'd1);
        end
        tick();
        check_eq("to_bus_err",  {31'd0, bus_error}, 32'd1);
        check_eq("to_result",   result_out, 32'd0);
        check_eq("to_stall_dn", {31'd0, stall_request}, 32'd0);
        check_eq("to_en_dn",    {31'd0, bus_if.ram_en}, 32'd0);
        tick();
        check_eq("to_bus_err_clr", {31'd0, bus_error}, 32'd0);

        // SW at 0x5000, reset during second ACCESS cycle
        set_op(0, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_5000);
        tick();
        check_eq("sw_we",    {28'd0, bus_if.ram_write_en}, 32'h0000_000F);
        check_eq("sw_wdata", bus_if.ram_write_data, 32'hCAFE_F00D);
        tick();
        check_eq("sw_en_c2", {31'd0, bus_if.ram_en}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("sw_rst_en",     {31'd0, bus_if.ram_en}, 32'd0);
        check_eq("sw_rst_we",     {28'd0, bus_if.ram_write_en}, 32'd0);
        check_eq("sw_rst_buserr", {31'd0, bus_error}, 32'd0);
        check_eq("sw_rst_addr",   bus_if.ram_addr, 32'd0);
        set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0000_0000);
        check_eq("sw_rst_stall",  {31'd0, stall_request}, 32'd0);

        // LBU at 0x6001 then an ADD back-to-back
        set_op(1, 0, 0, 4'b0001, 32'h0, 32'h0000_6001);
        tick();
        check_eq("lbu_addr", bus_if.ram_addr, 32'h0000_6000);
        bus_if.ram_ready     = 1'b1;
        bus_if.ram_read_data = 32'h0000_9A00;
        tick();
        bus_if.ram_ready = 1'b0;
        #1;
        check_eq("lbu_result", result_out, 32'h0000_009A);
        tick();
        set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0000_0042);
        check_eq("add_result", result_out, 32'h0000_0042);
        check_eq("add_stall",  {31'd0, stall_request}, 32'd0);
        tick();
        check_eq("add_ram_en", {31'd0, bus_if.ram_en}, 32'd0);
        check_eq("add_result2", result_out, 32'h0000_0042);

        // LH sign-extended at 0x7002
        set_op(1, 0, 1, 4'b0011, 32'h0, 32'h0000_7002);
        tick();
        bus_if.ram_ready     = 1'b1;
        bus_if.ram_read_data = 32'h8421_1234;
        tick();
        bus_if.ram_ready = 1'b0;
        #1;
        check_eq("lh_result", result_out, 32'hFFFF_8421);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

MEM-stage memory access unit, directly downstream of the ID-stage memory control generator (whose flags, byte select and store data travel through EX). Turns one load/store per instruction into a request on the data RAM bus: byte-lane alignment, store-data replication, ready/timeout handshake and load-data extraction with sign/zero extension. Holds the pipeline via `stall_request` until the access completes, then presents the write-back value.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles in ACCESS waiting for `ram_ready`; 0 disables the timeout.

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_read_flag`  in  1  load instruction
- `mem_write_flag`  in  1  store instruction
- `mem_sign_ext_flag`  in  1  sign-extend load data (LB/LH/LW)
- `mem_sel`  in  4  0001 byte, 0011 half, 1111 word, 0000 none
- `mem_write_data`  in  32  store source register value
- `result`  in  32  EX result; the effective address for memory ops
- `ram_ready`  in  1  bus completion, sampled while `ram_en`=1
- `ram_read_data`  in  32  full aligned word from RAM
- `ram_en`  out  1  bus request (registered)
- `ram_write_en`  out  4  per-byte write strobes (registered)
- `ram_addr`  out  32  word address `{result[31:2],2'b00}` (registered)
- `ram_write_data`  out  32  lane-replicated store data (registered)
- `result_out`  out  32  value forwarded to WB
- `stall_request`  out  1  hold all upstream stages
- `addr_error`  out  1  misaligned access this cycle (combinational)
- `bus_error`  out  1  timeout pulse, valid in DONE

## Operation
- Upstream holds every input stable while `stall_request`=1.
- Valid op: (`mem_read_flag` | `mem_write_flag`) and aligned. Misaligned: half with `result[0]`=1, word with `result[1:0]`≠0; byte never misaligned.
- FSM states IDLE, ACCESS, DONE.
- IDLE: non-mem op → `result_out`=`result`, stall 0. Misaligned → `addr_error`=1, `result_out`=0, stall 0, no bus access, stay IDLE. Valid op → stall 1, load bus registers, next ACCESS.
- Bus register load: `ram_en`=1; `ram_write_en` = store ? `mem_sel << result[1:0]` : 0; `ram_write_data`: byte `{4{wd[7:0]}}`, half `{2{wd[15:0]}}`, word `wd`.
- ACCESS: stall 1, bus outputs held. `ram_ready`=1 → capture `ram_read_data`, clear `ram_en`/`ram_write_en`, next DONE. Else timeout counter +1; when counter reaches `TIMEOUT_CYCLES`-1 without ready → captured data 0, `bus_error` set, next DONE.
- DONE: stall 0, `ram_en`=0. Load: `result_out` = captured word >> (8·`result[1:0]`), masked to byte/half, extended per `mem_sign_ext_flag`; LW unmodified. Store: `result_out`=`result`. `bus_error` high only here. Next IDLE unconditionally (next instruction arrives after this cycle's edge).
- Read and write flags both set: treat as store.
- Reset: from any state → IDLE; `ram_en`, `ram_write_en`, `ram_addr`, `ram_write_data`, captured data, counter, `bus_error` all 0. Mid-ACCESS reset drops the request with no completion.

## Timing
- Reset values: `ram_en`=0, `ram_write_en`=0, `ram_addr`=0, `ram_write_data`=0, `bus_error`=0; after reset the FSM is IDLE, so `stall_request`/`addr_error`/`result_out` follow IDLE rules from inputs.
- Cycle 0 op seen in IDLE (stall 1); cycle 1 `ram_en`=1; ready at cycle k≥1 → cycle k+1 DONE. Best case: 2 stall cycles, result in cycle 2.
- `stall_request`, `addr_error`, `result_out` combinational from state and inputs; no bus signal depends combinationally on `ram_ready`.
- Timeout: at most `TIMEOUT_CYCLES` cycles in ACCESS; ready in the final counted cycle wins over timeout.
- Exactly one `ram_en` assertion window per memory instruction; never re-issued in DONE.

## Test plan
- LB at `result`=0x1003, RAM word 0x80FF_FF12, ready on 1st ACCESS cycle → stall 1 for 2 cycles; `result_out`=0xFFFF_FF80 in DONE; `ram_addr`=0x1000.
- SH at 0x2002, wd=0x1234_ABCD, ready after 3 wait cycles → `ram_write_en`=1100, `ram_write_data`=0xABCD_ABCD held 4 cycles; stall drops in DONE.
- LW at 0x3001 → `addr_error`=1, stall 0, `ram_en` never 1, `result_out`=0.
- LHU at 0x4000, `ram_ready` stuck 0, TIMEOUT_CYCLES=4 → 4 ACCESS cycles, DONE with `bus_error`=1, `result_out`=0.
- SW at 0x5000, `rst`=1 in 2nd ACCESS cycle → next cycle IDLE, `ram_en`=0, `ram_write_en`=0, `bus_error`=0.
- ADD result 0x0000_0042 (no mem flags) back-to-back after an LBU completes → `result_out`=0x42 immediately, stall 0, no bus activity.
